// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and RAM status encoding.
package cpu_types;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of arbiter signals; arb is the arbiter's view, tb drives requesters and RAM.
interface mem_arbiter_if
    import cpu_types::*;
(
    input logic CLK
);
    logic        RST;
    logic        iREN;
    word_t       iaddr;
    logic        dREN;
    logic        dWEN;
    word_t       daddr;
    word_t       dstore;
    logic        iwait;
    logic        dwait;
    word_t       iload;
    word_t       dload;
    logic        ramREN;
    logic        ramWEN;
    word_t       ramaddr;
    word_t       ramstore;
    word_t       ramload;
    logic [1:0]  ramstate;
    logic        err;

    modport arb (
        input  CLK, RST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport tb (
        input  CLK, iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err,
        output RST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate
    );

endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants taken while an instruction fetch waits.
module arb_starve_ctr #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);
    localparam int unsigned W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != W'(LIMIT))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == W'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Two-master RAM arbiter: data has priority, instruction fetch wins after STARVE_LIMIT data grants.
module mem_arbiter
    import cpu_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} arb_state_t;

    arb_state_t state_q;
    arb_state_t state_d;
    ramstate_t  rs;
    logic       dreq;
    logic       at_limit;
    logic       cnt_clr;
    logic       cnt_inc;
    logic       icomp;
    logic       dcomp;

    assign rs   = ramstate_t'(ramstate);
    assign dreq = dREN | dWEN;

    arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk      (CLK),
        .rst      (RST),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .at_limit (at_limit)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        icomp    = 1'b0;
        dcomp    = 1'b0;
        err      = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (iREN && (at_limit || !dreq)) begin
                    state_d = IGRANT;
                    cnt_clr = 1'b1;
                end else if (dreq) begin
                    state_d = DGRANT;
                    cnt_inc = iREN;
                end
                if (!iREN) begin
                    cnt_clr = 1'b1;
                end
            end
            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                // A dropped request aborts even if the RAM reports ACCESS/ERROR this cycle.
                if (!iREN) begin
                    state_d = IDLE;
                end else if (rs == ACCESS) begin
                    icomp   = 1'b1;
                    iload   = ramload;
                    state_d = IDLE;
                end else if (rs == ERROR) begin
                    err     = 1'b1;
                    state_d = IDLE;
                end
            end
            DGRANT: begin
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (!dreq) begin
                    state_d = IDLE;
                end else if (rs == ACCESS) begin
                    dcomp   = 1'b1;
                    dload   = ramload;
                    state_d = IDLE;
                end else if (rs == ERROR) begin
                    err     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign iwait = iREN & ~icomp;
    assign dwait = dreq & ~dcomp;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded directed bench for mem_arbiter; the bench plays both requesters and the RAM.
module tb_mem_arbiter;
    import cpu_types::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus (.CLK(clk));

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK      (bus.CLK),
        .RST      (bus.RST),
        .iREN     (bus.iREN),
        .iaddr    (bus.iaddr),
        .dREN     (bus.dREN),
        .dWEN     (bus.dWEN),
        .daddr    (bus.daddr),
        .dstore   (bus.dstore),
        .iwait    (bus.iwait),
        .dwait    (bus.dwait),
        .iload    (bus.iload),
        .dload    (bus.dload),
        .ramREN   (bus.ramREN),
        .ramWEN   (bus.ramWEN),
        .ramaddr  (bus.ramaddr),
        .ramstore (bus.ramstore),
        .ramload  (bus.ramload),
        .ramstate (bus.ramstate),
        .err      (bus.err)
    );

    localparam logic [31:0] BG_LOAD = 32'hBAD0_BAD0;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    word_t exp_i[$];
    word_t exp_d[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic chk_strobes(input string tag, input logic ren, input logic wen, input logic [31:0] addr);
        check({tag, "_ren"},  32'(bus.ramREN), 32'(ren));
        check({tag, "_wen"},  32'(bus.ramWEN), 32'(wen));
        check({tag, "_addr"}, bus.ramaddr, addr);
    endtask

    // Completion monitor: pops the scoreboard whenever a pending request stops waiting.
    always @(negedge clk) begin
        if (bus.RST === 1'b0) begin
            if (bus.iREN && !bus.iwait) begin
                if (exp_i.size() == 0) check("sb_i_unexpected", 32'(exp_i.size()), 32'd1);
                else check("iload", bus.iload, exp_i.pop_front());
            end else begin
                check("iload_zero", bus.iload, 32'h0);
            end
            if ((bus.dREN || bus.dWEN) && !bus.dwait) begin
                if (exp_d.size() == 0) check("sb_d_unexpected", 32'(exp_d.size()), 32'd1);
                else check("dload", bus.dload, exp_d.pop_front());
            end else begin
                check("dload_zero", bus.dload, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.RST = 1'b1; bus.iREN = 1'b0; bus.iaddr = '0;
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
        bus.ramload = BG_LOAD; bus.ramstate = FREE;

        // Reset state
        cyc(); cyc(); neg();
        chk_strobes("rst", 1'b0, 1'b0, 32'h0);
        check("rst_store", bus.ramstore, 32'h0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_starve", 32'(dut.u_starve.cnt_q), 32'd0);
        cyc(); bus.RST = 1'b0; neg();

        // Single fetch: arbitration cycle, then completion in the first IGRANT cycle
        cyc(); bus.iREN = 1'b1; bus.iaddr = 32'h40; neg();
        chk_strobes("f_arb", 1'b0, 1'b0, 32'h0);
        check("f_arb_iwait", 32'(bus.iwait), 32'd1);
        cyc(); bus.ramstate = ACCESS; bus.ramload = 32'h2108_000A; exp_i.push_back(32'h2108_000A); neg();
        chk_strobes("f_grant", 1'b1, 1'b0, 32'h40);
        check("f_grant_iwait", 32'(bus.iwait), 32'd0);
        cyc(); bus.iREN = 1'b0; bus.ramstate = FREE; bus.ramload = BG_LOAD; neg();
        chk_strobes("f_idle", 1'b0, 1'b0, 32'h0);

        // Collision: data first, bubble, then instruction
        cyc(); bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.dREN = 1'b1; bus.daddr = 32'h100; neg();
        cyc(); bus.ramstate = ACCESS; bus.ramload = 32'h1111_0000; exp_d.push_back(32'h1111_0000); neg();
        chk_strobes("c_dgrant", 1'b1, 1'b0, 32'h100);
        check("c_dgrant_iwait", 32'(bus.iwait), 32'd1);
        cyc(); bus.dREN = 1'b0; bus.ramstate = FREE; bus.ramload = BG_LOAD; neg();
        chk_strobes("c_bubble", 1'b0, 1'b0, 32'h0);
        cyc(); bus.ramstate = ACCESS; bus.ramload = 32'h2222_0000; exp_i.push_back(32'h2222_0000); neg();
        chk_strobes("c_igrant", 1'b1, 1'b0, 32'h80);
        cyc(); bus.iREN = 1'b0; bus.ramstate = FREE; bus.ramload = BG_LOAD; neg();

        // Starvation: four data grants, then the fetch wins although dREN stays high
        cyc(); bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.dREN = 1'b1; bus.daddr = 32'h300; neg();
        for (int k = 0; k < 4; k++) begin
            cyc();
            bus.ramstate = ACCESS; bus.ramload = 32'hD000_0000 + 32'(k);
            exp_d.push_back(32'hD000_0000 + 32'(k));
            neg();
            chk_strobes($sformatf("s_dgrant%0d", k), 1'b1, 1'b0, bus.daddr);
            cyc(); bus.ramstate = FREE; bus.ramload = BG_LOAD; bus.daddr = bus.daddr + 32'h4; neg();
            chk_strobes($sformatf("s_bubble%0d", k), 1'b0, 1'b0, 32'h0);
        end
        cyc(); bus.ramstate = ACCESS; bus.ramload = 32'h5555_AAAA; exp_i.push_back(32'h5555_AAAA); neg();
        chk_strobes("s_igrant", 1'b1, 1'b0, 32'h44);
        check("s_igrant_dwait", 32'(bus.dwait), 32'd1);
        cyc(); bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ramstate = FREE; bus.ramload = BG_LOAD; neg();
        chk_strobes("s_idle", 1'b0, 1'b0, 32'h0);

        // Fetch dropped mid-grant: abort, and a late ACCESS completes nothing
        cyc(); bus.iREN = 1'b1; bus.iaddr = 32'h60; neg();
        cyc(); bus.ramstate = BUSY; neg();
        chk_strobes("a_igrant", 1'b1, 1'b0, 32'h60);
        cyc(); bus.iREN = 1'b0; neg();
        cyc(); bus.ramstate = ACCESS; neg();
        chk_strobes("a_idle", 1'b0, 1'b0, 32'h0);
        check("a_iwait", 32'(bus.iwait), 32'd0);
        cyc(); bus.ramstate = FREE; neg();

        // Write/read conflict: the write wins
        cyc(); bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'hDEAD_BEEF; neg();
        cyc(); bus.ramstate = ACCESS; bus.ramload = 32'h5A5A_5A5A; exp_d.push_back(32'h5A5A_5A5A); neg();
        chk_strobes("w_grant", 1'b0, 1'b1, 32'h200);
        check("w_store", bus.ramstore, 32'hDEAD_BEEF);
        cyc(); bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.ramstate = FREE; bus.ramload = BG_LOAD; neg();

        // Wait states then ERROR: strobes hold, err pulses once, re-grant succeeds
        cyc(); bus.dREN = 1'b1; bus.daddr = 32'h240; neg();
        for (int k = 0; k < 3; k++) begin
            cyc(); bus.ramstate = BUSY; neg();
            chk_strobes($sformatf("e_busy%0d", k), 1'b1, 1'b0, 32'h240);
            check($sformatf("e_busy%0d_err", k), 32'(bus.err), 32'd0);
        end
        cyc(); bus.ramstate = ERROR; neg();
        check("e_err", 32'(bus.err), 32'd1);
        check("e_err_dwait", 32'(bus.dwait), 32'd1);
        cyc(); bus.ramstate = FREE; neg();
        chk_strobes("e_idle", 1'b0, 1'b0, 32'h0);
        check("e_idle_err", 32'(bus.err), 32'd0);
        check("e_idle_dwait", 32'(bus.dwait), 32'd1);
        cyc(); bus.ramstate = ACCESS; bus.ramload = 32'h0BAD_F00D; exp_d.push_back(32'h0BAD_F00D); neg();
        chk_strobes("e_regrant", 1'b1, 1'b0, 32'h240);
        cyc(); bus.dREN = 1'b0; bus.ramstate = FREE; bus.ramload = BG_LOAD; neg();

        // Reset during a BUSY data grant
        cyc(); bus.iREN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h280; neg();
        cyc(); bus.ramstate = BUSY; neg();
        chk_strobes("r_dgrant", 1'b1, 1'b0, 32'h280);
        check("r_starve_pre", 32'(dut.u_starve.cnt_q), 32'd1);
        bus.RST = 1'b1;
        cyc(); neg();
        chk_strobes("r_after", 1'b0, 1'b0, 32'h0);
        check("r_starve", 32'(dut.u_starve.cnt_q), 32'd0);
        bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ramstate = FREE;
        cyc(); bus.RST = 1'b0; neg();
        cyc(); neg();

        check("sb_i_left", 32'(exp_i.size()), 32'd0);
        check("sb_d_left", 32'(exp_d.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: number of consecutive data grants made while an instruction request waits, after which the instruction request wins the next arbitration.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 iREN  input  1  instruction fetch request.
REQ-005 iaddr  input  32  instruction word address.
REQ-006 dREN  input  1  data read request.
REQ-007 dWEN  input  1  data write request.
REQ-008 daddr  input  32  data address.
REQ-009 dstore  input  32  data write value.
REQ-010 iwait  output  1  high while an instruction request is pending and not yet completed.
REQ-011 dwait  output  1  high while a data request is pending and not yet completed.
REQ-012 iload  output  32  fetched instruction word; valid in the completion cycle.
REQ-013 dload  output  32  loaded data word; valid in the completion cycle.
REQ-014 ramREN, ramWEN  output  1 each  RAM read and write strobes.
REQ-015 ramaddr, ramstore  output  32 each  RAM address and write data.
REQ-016 ramload  input  32  RAM read data.
REQ-017 ramstate  input  2  RAM status: FREE, BUSY, ACCESS, ERROR.
REQ-018 err  output  1  one-cycle pulse when a granted transaction ends in ERROR.

Function
REQ-019 The FSM SHALL have three states: IDLE, IGRANT, DGRANT.
REQ-020 In IDLE, with any request present, the next state SHALL be DGRANT or IGRANT; with no request it SHALL remain IDLE.
- Data priority: DGRANT wins unless iREN is high and starve_cnt equals STARVE_LIMIT.
REQ-021 starve_cnt SHALL:
- increment (saturating at STARVE_LIMIT) on each IDLE->DGRANT transition taken while iREN is high;
- clear on each IDLE->IGRANT transition and whenever iREN is low in IDLE.
REQ-022 In DGRANT, ramaddr SHALL be daddr.
- ramWEN SHALL be dWEN.
- ramREN SHALL be dREN AND NOT dWEN, so a write wins if dREN and dWEN are both high.
- ramstore SHALL be dstore.
REQ-023 In IGRANT, ramREN SHALL be 1, ramWEN SHALL be 0 and ramaddr SHALL be iaddr.
REQ-024 In IDLE, ramREN and ramWEN SHALL be 0; ramaddr and ramstore SHALL be 0.
REQ-025 A granted transaction SHALL complete in the first cycle in which ramstate is ACCESS.
- Completion deasserts the matching wait output in that cycle.
- iload or dload SHALL equal ramload in that cycle.
- The next state SHALL be IDLE.
REQ-026 ramstate ERROR in a grant state SHALL return the FSM to IDLE and pulse err for one cycle.
- The wait output stays high; the requester is retried through normal arbitration.
REQ-027 FREE or BUSY in a grant state SHALL hold the state and keep RAM strobes stable.
REQ-028 If the granted request drops mid-grant, the FSM SHALL abort to IDLE on the next edge with no completion.
- Drop means dREN=dWEN=0 in DGRANT, or iREN=0 in IGRANT.
REQ-029 iwait SHALL equal iREN AND NOT (IGRANT completion); dwait SHALL equal (dREN OR dWEN) AND NOT (DGRANT completion).
REQ-030 Minimum latency SHALL be 2 cycles from request to completion: arbitration cycle plus the first grant cycle with ACCESS.
- One IDLE bubble SHALL follow every completion.
REQ-031 iload and dload SHALL be 0 outside their completion cycle.

Reset
REQ-032 With RST high at a rising edge, state SHALL become IDLE, starve_cnt 0 and err 0, including mid-transaction.
- ram strobes therefore read 0 in the following cycle.

Structure
REQ-033 word_t (32-bit) and ramstate_t (FREE, BUSY, ACCESS, ERROR) SHALL live in the shared cpu_types package.
- The arbiter state enum SHALL be local to the module.
REQ-034 A sub-module arb_starve_ctr (saturating counter, clear/increment inputs, at_limit output) SHALL implement starve_cnt.
REQ-035 A mem_arbiter_if interface SHALL carry the ports, with modports arb and tb.

Verification
REQ-036 Single fetch: iREN=1, iaddr=0x40; ramstate ACCESS in the first IGRANT cycle with ramload=0x2108000A -> iwait low and iload=0x2108000A in cycle 2, IDLE in cycle 3.
REQ-037 Collision: iREN=1 and dREN=1 (daddr=0x100) in the same cycle -> DGRANT first; after completion and the IDLE bubble -> IGRANT.
REQ-038 Starvation: iREN held high, data requests back-to-back, STARVE_LIMIT=4 -> after 4 data grants, the 5th arbitration selects IGRANT even though dREN=1.
REQ-039 Write/read conflict: dREN=dWEN=1, daddr=0x200, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
REQ-040 Wait states and error: ramstate BUSY for 3 cycles, then ERROR -> strobes stable for 3 cycles, err pulses once, dwait stays high, re-grant follows.
REQ-041 Reset mid-grant: RST asserted during DGRANT with ramstate BUSY -> IDLE, ramREN=ramWEN=0 and starve_cnt=0 on the next cycle.
